branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit saturating BHT with lookup at fetch and update at execute, flag-based
// branch resolution, registered mispredict flush/redirect and saturating statistics counters.
module branch_predict_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            branch,
  input  logic [2:0]      func3,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            resBranch,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic [1:0]          bht_q [Entries];
  logic                flush_q;
  logic [XLEN-1:0]     redirect_q;
  logic [CNT_W-1:0]    br_count_q;
  logic [CNT_W-1:0]    mp_count_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                cond_known;
  logic                res_taken;
  logic                resolve;
  logic                mispredict;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];

  // Reads the registered table, so a same-cycle update is not bypassed.
  assign pred_taken = if_valid & if_is_branch & bht_q[if_idx][1];

  always_comb begin
    cond_known = 1'b1;
    res_taken  = 1'b0;
    unique case (func3)
      3'b000:  res_taken = zf;
      3'b001:  res_taken = ~zf;
      3'b100:  res_taken = sf != vf;
      3'b101:  res_taken = sf == vf;
      3'b110:  res_taken = ~cf;
      3'b111:  res_taken = cf;
      default: cond_known = 1'b0;
    endcase
  end

  assign resolve    = ex_valid & branch & cond_known;
  assign resBranch  = resolve & res_taken;
  assign mispredict = resolve & (resBranch != ex_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        bht_q[i] <= 2'b01;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= resBranch ? ex_target : ex_pc + XLEN'(4);
      end
      if (resolve) begin
        if (resBranch && bht_q[ex_idx] != 2'b11) begin
          bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
        end else if (!resBranch && bht_q[ex_idx] != 2'b00) begin
          bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
        end
        if (br_count_q != '1) begin
          br_count_q <= br_count_q + 1'b1;
        end
      end
      if (mispredict && mp_count_q != '1) begin
        mp_count_q <= mp_count_q + 1'b1;
      end
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule
